// File: rtl/mem_pkg.sv
// Shared types for the data-side memory responder: access modes, FSM states, lane widths.
package mem_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MERGE,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extract with sign/zero extension for loads, and lane merge for stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_mode_t         mode,
  input  logic [1:0]        off,
  input  logic              ld_unsigned,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] ld_data_c,
  output logic [WORD_W-1:0] st_word_c
);

  logic [4:0]        sh_b;
  logic [4:0]        sh_h;
  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  assign sh_b   = {off, 3'b000};
  assign sh_h   = {off[1], 4'b0000};
  assign lane_b = BYTE_W'(word >> sh_b);
  assign lane_h = HALF_W'(word >> sh_h);

  always_comb begin
    ld_data_c = word;
    st_word_c = wdata;
    case (mode)
      MEM_BYTE: begin
        ld_data_c = ld_unsigned ? WORD_W'(lane_b)
                                : {{(WORD_W-BYTE_W){lane_b[BYTE_W-1]}}, lane_b};
        st_word_c = (word & ~(WORD_W'(8'hFF) << sh_b))
                  | (WORD_W'(wdata[BYTE_W-1:0]) << sh_b);
      end
      MEM_HALF: begin
        ld_data_c = ld_unsigned ? WORD_W'(lane_h)
                                : {{(WORD_W-HALF_W){lane_h[HALF_W-1]}}, lane_h};
        st_word_c = (word & ~(WORD_W'(16'hFFFF) << sh_h))
                  | (WORD_W'(wdata[HALF_W-1:0]) << sh_h);
      end
      default: begin
        ld_data_c = word;
        st_word_c = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// req/ready memory responder: sub-word loads and read-modify-write stores over a sync-read RAM.
// MEM_MISALIGN_TRAP_EN: misaligned accesses complete with err instead of being force-aligned.
module mem_rmw_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        mem_mode,
  input  logic              ld_unsigned,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic              we_q, we_d;
  mem_mode_t         mode_q, mode_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       old_q, old_d;
  logic [31:0]       rdata_q, rdata_d;

  mem_mode_t         mode_in;
  logic [1:0]        off_in;
  logic              trap_c;
  logic              ram_we_c;
  logic [31:0]       align_word;
  logic [31:0]       ld_data_c;
  logic [31:0]       st_word_c;
  logic              unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  // Encoding 11 behaves as a word access.
  assign mode_in = (mem_mode == 2'b11) ? MEM_WORD : mem_mode_t'(mem_mode);

  // Offset cleared to the access size, so misaligned requests land on the containing lane.
  always_comb begin
    case (mode_in)
      MEM_BYTE: off_in = addr[1:0];
      MEM_HALF: off_in = {addr[1], 1'b0};
      default:  off_in = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic err_q, err_d;
  assign trap_c = (mode_in == MEM_HALF) ? addr[0] :
                  (mode_in == MEM_WORD) ? (addr[1:0] != 2'b00) : 1'b0;
  assign err    = err_q & (state_q == DONE);
`else
  assign trap_c = 1'b0;
  assign err    = 1'b0;
`endif

  // Same aligner serves load extraction (live RAM word) and store merge (captured old word).
  assign align_word = (state_q == MERGE) ? old_q : ram_rdata;

  mem_lane_align u_align (
    .mode        (mode_q),
    .off         (off_q),
    .ld_unsigned (uns_q),
    .word        (align_word),
    .wdata       (wdata_q),
    .ld_data_c   (ld_data_c),
    .st_word_c   (st_word_c)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    off_d     = off_q;
    we_d      = we_q;
    mode_d    = mode_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    old_d     = old_q;
    rdata_d   = rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    err_d     = err_q;
`endif
    ram_we_c  = 1'b0;
    ram_addr  = idx_q;
    ram_wdata = st_word_c;
    case (state_q)
      IDLE: begin
        ram_addr = addr[ADDR_W+1:2];
        if (req) begin
          idx_d   = addr[ADDR_W+1:2];
          off_d   = off_in;
          we_d    = we;
          mode_d  = mode_in;
          uns_d   = ld_unsigned;
          wdata_d = wdata;
`ifdef MEM_MISALIGN_TRAP_EN
          err_d   = trap_c;
`endif
          if (trap_c) begin
            state_d = DONE;
          end else if (we && (mode_in == MEM_WORD)) begin
            ram_we_c  = 1'b1;
            ram_wdata = wdata;
            state_d   = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (we_q) begin
          old_d   = ram_rdata;
          state_d = MERGE;
        end else begin
          rdata_d = ld_data_c;
          state_d = DONE;
        end
      end
      MERGE: begin
        ram_we_c = 1'b1;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      mode_q  <= MEM_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Gated by reset so no write can escape while the controller is held in reset.
  assign ram_we = ram_we_c & reset;
  assign ready  = (state_q == DONE);
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Directed bench for mem_rmw_ctrl against a behavioural sync-read RAM.
module tb_mem_rmw_ctrl;
  import mem_pkg::*;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [1:0]        mem_mode = 2'b00;
  logic              ld_unsigned = 1'b0;
  logic [31:0]       addr = '0;
  logic [31:0]       wdata = '0;
  logic              ready;
  logic [31:0]       rdata;
  logic              err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  mem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .mem_mode    (mem_mode),
    .ld_unsigned (ld_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .rdata       (rdata),
    .err         (err),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access; cycle 0 is the acceptance cycle. addr/wdata are scrambled after acceptance.
  task automatic access(input logic st, input logic [1:0] md, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int rdy_cyc, output logic [15:0] we_mask,
                        output logic [31:0] rd, output logic er);
    rdy_cyc = -1;
    we_mask = '0;
    rd      = '0;
    er      = 1'b0;
    @(negedge clk);
    req = 1'b1; we = st; mem_mode = md; ld_unsigned = uns; addr = a; wdata = wd;
    #1;
    for (int n = 0; n < 12; n++) begin
      if (ram_we === 1'b1) we_mask[n] = 1'b1;
      if (ready === 1'b1) begin
        rdy_cyc = n; rd = rdata; er = err;
        break;
      end
      @(posedge clk); #1;
      if (n == 0) begin addr = ~a; wdata = ~wd; end
      @(negedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic run(input string tag, input logic st, input logic [1:0] md, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_cyc, input logic [15:0] exp_mask,
                     input logic [31:0] exp_rd, input logic exp_er);
    int          c;
    logic [15:0] m;
    logic [31:0] r;
    logic        e;
    access(st, md, uns, a, wd, c, m, r, e);
    check({tag, " ready_cycle"}, 32'(c), 32'(exp_cyc));
    check({tag, " ram_we_cycles"}, 32'(m), 32'(exp_mask));
    check({tag, " rdata"}, r, exp_rd);
    check({tag, " err"}, 32'(e), 32'(exp_er));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    ram[16] = 32'h8899_AABB;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset ram_we", 32'(ram_we), 32'd0);
    check("reset rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    run("lb 0x41",  1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 2, 16'h0, 32'hFFFF_FFAA, 1'b0);
    run("lbu 0x41", 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 2, 16'h0, 32'h0000_00AA, 1'b0);
    run("lh 0x42",  1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 2, 16'h0, 32'hFFFF_8899, 1'b0);
    run("lbu 0x43", 1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 2, 16'h0, 32'h0000_0088, 1'b0);
    run("lhu 0x40", 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 2, 16'h0, 32'h0000_AABB, 1'b0);

    run("sb 0x43",  1'b1, 2'b00, 1'b0, 32'h43, 32'h1234_5677, 3, 16'h0004, 32'h0000_AABB, 1'b0);
    check("sb 0x43 ram", ram[16], 32'h7799_AABB);

    run("lw mode11", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 2, 16'h0, 32'h7799_AABB, 1'b0);

    run("sw 0x40",  1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 1, 16'h0001, 32'h7799_AABB, 1'b0);
    run("b2b lbu",  1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 2, 16'h0, 32'h0000_00EF, 1'b0);
    check("sw 0x40 ram", ram[16], 32'hDEAD_BEEF);

    // Reset lands while the half store is in MERGE.
    @(negedge clk);
    req = 1'b1; we = 1'b1; mem_mode = 2'b01; ld_unsigned = 1'b0; addr = 32'h42; wdata = 32'h0000_CAFE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    #1;
    check("rst merge ram_we", 32'(ram_we), 32'd0);
    check("rst merge ready", 32'(ready), 32'd0);
    check("rst merge rdata", rdata, 32'h0);
    check("rst merge err", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("rst merge ram", ram[16], 32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b1;

    run("lh after rst", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 2, 16'h0, 32'hFFFF_DEAD, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
    run("sh 0x41 trap", 1'b1, 2'b01, 1'b0, 32'h41, 32'hFFFF_1234, 1, 16'h0, 32'hFFFF_DEAD, 1'b1);
    check("sh 0x41 ram", ram[16], 32'hDEAD_BEEF);
    run("lw 0x42 trap", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1, 16'h0, 32'hFFFF_DEAD, 1'b1);
`else
    run("sh 0x41 align", 1'b1, 2'b01, 1'b0, 32'h41, 32'hFFFF_1234, 3, 16'h0004, 32'hFFFF_DEAD, 1'b0);
    check("sh 0x41 ram", ram[16], 32'hDEAD_1234);
    run("lw 0x42 align", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 2, 16'h0, 32'hDEAD_1234, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
